// File: rtl/core_lb_hub.sv
// ---------------------------------------------------------------------------
// core_lb_hub
//   Local-bus hub in front of NUM_CH capture-channel slaves (sump2 instances).
//   Decodes the byte address, forwards channel accesses one cycle later, and
//   runs a small IDLE/WAIT/DONE read FSM that waits for the selected channel's
//   ready pulse. It also implements the hub registers: ID, scratch and status.
//   Bus errors (unmapped accesses, reads while busy, and read timeouts) go to a
//   saturating 16-bit counter.
//
//   Optional build macro: CORE_LB_TIMEOUT_EN. When it is defined, a channel
//   read that waits TIMEOUT_CYC cycles without ready completes with
//   32'hDEADBEEF and counts as an error.
//
// Ports
//   clk_lb      in   local-bus clock, rising edge
//   reset       in   synchronous active-high reset
//   lb_wr       in   single-cycle write strobe
//   lb_rd       in   single-cycle read strobe
//   lb_addr     in   byte address; only [7:2] are decoded
//   lb_wr_d     in   write data
//   lb_rd_d     out  read data, valid while lb_rd_rdy=1, else 0
//   lb_rd_rdy   out  single-cycle read-complete pulse
//   ch_cs_ctrl  out  per-channel control-register select
//   ch_cs_data  out  per-channel data-register select
//   ch_wr       out  forwarded write strobe
//   ch_rd       out  forwarded read strobe
//   ch_wr_d     out  forwarded write data
//   ch_rd_d     in   channel read data, channel k at [32k+31:32k]
//   ch_rd_rdy   in   channel read-ready pulses
//   err_cnt     out  saturating bus-error count
// ---------------------------------------------------------------------------
module core_lb_hub #(
    parameter int          NUM_CH      = 4,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] HUB_ID      = 32'h53554D50
) (
    input  logic                 clk_lb,
    input  logic                 reset,
    input  logic                 lb_wr,
    input  logic                 lb_rd,
    input  logic [31:0]          lb_addr,
    input  logic [31:0]          lb_wr_d,
    output logic [31:0]          lb_rd_d,
    output logic                 lb_rd_rdy,
    output logic [NUM_CH-1:0]    ch_cs_ctrl,
    output logic [NUM_CH-1:0]    ch_cs_data,
    output logic                 ch_wr,
    output logic                 ch_rd,
    output logic [31:0]          ch_wr_d,
    input  logic [NUM_CH*32-1:0] ch_rd_d,
    input  logic [NUM_CH-1:0]    ch_rd_rdy,
    output logic [15:0]          err_cnt
);

    localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state;
    logic [CH_W-1:0] rd_ch;     // channel owning the outstanding read
    logic [31:0]     scratch;

    // ---------------- address decode ----------------
    logic [3:0]      page;
    logic [1:0]      hub_reg;
    logic            is_ch;
    logic            is_hub;
    logic            mapped;
    logic [CH_W-1:0] ch_idx;

    assign page    = lb_addr[7:4];
    assign hub_reg = lb_addr[3:2];
    assign is_ch   = ({1'b0, page} < 5'(NUM_CH));
    assign is_hub  = (page == 4'hF);
    assign ch_idx  = page[CH_W-1:0];
    // 0xFC has no register behind it and is treated like any unmapped address.
    assign mapped  = is_ch || (is_hub && hub_reg != 2'd3);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{lb_addr[31:8], lb_addr[1:0]};

    // ---------------- access qualification ----------------
    logic idle;
    logic fwd_wr;
    logic fwd_rd;
    logic hub_rd;
    logic wr_err;
    logic rd_err;
    logic clr_err;

    assign idle    = (state == ST_IDLE);
    // Writes are forwarded in any state; reads only start from IDLE.
    assign fwd_wr  = lb_wr && is_ch;
    assign fwd_rd  = lb_rd && idle && is_ch;
    assign hub_rd  = lb_rd && idle && !is_ch;   // hub register or unmapped
    assign wr_err  = lb_wr && !mapped;
    assign rd_err  = lb_rd && (!idle || !mapped);
    assign clr_err = lb_wr && is_hub && (hub_reg == 2'd2) && lb_wr_d[31];

    logic [31:0] hub_rdata;
    always_comb begin
        // NOTE: every path assigns hub_rdata, so no latch is inferred.
        hub_rdata = BAD_DATA;
        if (is_hub) begin
            case (hub_reg)
                2'd0:    hub_rdata = HUB_ID;
                2'd1:    hub_rdata = scratch;
                2'd2:    hub_rdata = {err_cnt, 12'd0, 4'(NUM_CH)};
                default: hub_rdata = BAD_DATA;
            endcase
        end
    end

    logic [NUM_CH-1:0] ch_onehot;
    always_comb begin
        ch_onehot         = '0;
        ch_onehot[ch_idx] = 1'b1;
    end

    // Only the channel that owns the read is observed.
    logic        sel_rdy;
    logic [31:0] sel_data;
    assign sel_rdy  = ch_rd_rdy[rd_ch];
    assign sel_data = ch_rd_d[32*rd_ch +: 32];

    // ---------------- optional read timeout ----------------
    logic to_fire;
`ifdef CORE_LB_TIMEOUT_EN
    logic [15:0] to_cnt;

    always_ff @(posedge clk_lb) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT && !sel_rdy) begin
            to_cnt <= to_cnt + 16'd1;
        end else begin
            to_cnt <= '0;
        end
    end

    // When ready and timeout land in the same cycle, ready wins.
    assign to_fire = (state == ST_WAIT) && !sel_rdy && (to_cnt == 16'(TIMEOUT_CYC - 1));
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYC);
    assign to_fire        = 1'b0;
`endif

    // ---------------- error counter arithmetic ----------------
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    assign err_inc = {1'b0, wr_err} + {1'b0, rd_err} + {1'b0, to_fire};
    assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};

    // ---------------- sequential logic ----------------
    // NOTE: reset is tested first, so strobes presented during reset are
    // dropped, and all state uses non-blocking assignments.
    always_ff @(posedge clk_lb) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_ch      <= '0;
            scratch    <= '0;
            err_cnt    <= '0;
            lb_rd_d    <= '0;
            lb_rd_rdy  <= 1'b0;
            ch_cs_ctrl <= '0;
            ch_cs_data <= '0;
            ch_wr      <= 1'b0;
            ch_rd      <= 1'b0;
            ch_wr_d    <= '0;
        end else begin
            lb_rd_rdy <= 1'b0;
            lb_rd_d   <= '0;
            ch_wr     <= fwd_wr;
            ch_rd     <= fwd_rd;

            if (fwd_wr || fwd_rd) begin
                ch_cs_ctrl <= lb_addr[2] ? '0 : ch_onehot;
                ch_cs_data <= lb_addr[2] ? ch_onehot : '0;
                ch_wr_d    <= lb_wr_d;
            end

            if (lb_wr && is_hub && hub_reg == 2'd1) begin
                scratch <= lb_wr_d;
            end

            if (clr_err) begin
                err_cnt <= '0;
            end else if (err_sum[16]) begin
                err_cnt <= 16'hFFFF;
            end else begin
                err_cnt <= err_sum[15:0];
            end

            case (state)
                ST_IDLE: begin
                    if (fwd_rd) begin
                        rd_ch <= ch_idx;
                        state <= ST_WAIT;
                    end else if (hub_rd) begin
                        lb_rd_rdy <= 1'b1;
                        lb_rd_d   <= hub_rdata;
                    end
                end
                ST_WAIT: begin
                    // lb_rd_rdy is raised here so it is high during DONE.
                    if (sel_rdy) begin
                        lb_rd_rdy <= 1'b1;
                        lb_rd_d   <= sel_data;
                        state     <= ST_DONE;
                    end else if (to_fire) begin
                        lb_rd_rdy <= 1'b1;
                        lb_rd_d   <= BAD_DATA;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lb_hub.sv
// ---------------------------------------------------------------------------
// tb_core_lb_hub
//   Directed bench for core_lb_hub with NUM_CH=4 and TIMEOUT_CYC=8. A table of
//   single-access vectors covers the hub registers, unmapped addresses and
//   channel writes. Hand-written sequences cover channel reads, busy reads,
//   simultaneous write+read, error saturation/clear, reset during WAIT and the
//   optional CORE_LB_TIMEOUT_EN behaviour.
//   Inputs are driven on the falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_core_lb_hub;

    logic         clk_lb = 1'b0;
    logic         reset;
    logic         lb_wr;
    logic         lb_rd;
    logic [31:0]  lb_addr;
    logic [31:0]  lb_wr_d;
    logic [31:0]  lb_rd_d;
    logic         lb_rd_rdy;
    logic [3:0]   ch_cs_ctrl;
    logic [3:0]   ch_cs_data;
    logic         ch_wr;
    logic         ch_rd;
    logic [31:0]  ch_wr_d;
    logic [127:0] ch_rd_d;
    logic [3:0]   ch_rd_rdy;
    logic [15:0]  err_cnt;

    always #5 clk_lb = ~clk_lb;

    core_lb_hub #(
        .NUM_CH      (4),
        .TIMEOUT_CYC (8),
        .HUB_ID      (32'h53554D50)
    ) dut (
        .clk_lb     (clk_lb),
        .reset      (reset),
        .lb_wr      (lb_wr),
        .lb_rd      (lb_rd),
        .lb_addr    (lb_addr),
        .lb_wr_d    (lb_wr_d),
        .lb_rd_d    (lb_rd_d),
        .lb_rd_rdy  (lb_rd_rdy),
        .ch_cs_ctrl (ch_cs_ctrl),
        .ch_cs_data (ch_cs_data),
        .ch_wr      (ch_wr),
        .ch_rd      (ch_rd),
        .ch_wr_d    (ch_wr_d),
        .ch_rd_d    (ch_rd_d),
        .ch_rd_rdy  (ch_rd_rdy),
        .err_cnt    (err_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Read-completion bookkeeping for the multi-cycle sequences.
    int          rdy_n;
    int          rdy_k;
    logic [31:0] rdy_d;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_rdy;
        logic [31:0] exp_d;
        logic [15:0] exp_err;
        logic        chk_ch;
        logic [3:0]  exp_cs_ctrl;
        logic [3:0]  exp_cs_data;
        logic        exp_ch_wr;
        logic [31:0] exp_ch_wr_d;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                                input logic [31:0] wd, input logic exp_rdy,
                                input logic [31:0] exp_d, input logic [15:0] exp_err,
                                input logic chk_ch, input logic [3:0] cs_ctrl,
                                input logic [3:0] cs_data, input logic chwr,
                                input logic [31:0] chwd);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd;
        v.exp_rdy = exp_rdy; v.exp_d = exp_d; v.exp_err = exp_err;
        v.chk_ch = chk_ch; v.exp_cs_ctrl = cs_ctrl; v.exp_cs_data = cs_data;
        v.exp_ch_wr = chwr; v.exp_ch_wr_d = chwd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One access: strobes high for exactly one cycle. Returns at the falling
    // edge after the strobe edge, where the registered response is visible.
    task automatic bus_op(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wd);
        @(negedge clk_lb);
        lb_wr   = wr;
        lb_rd   = rd;
        lb_addr = addr;
        lb_wr_d = wd;
        @(negedge clk_lb);
        lb_wr = 1'b0;
        lb_rd = 1'b0;
    endtask

    task automatic note_rdy(input int k);
        if (lb_rd_rdy === 1'b1) begin
            rdy_n++;
            rdy_k = k;
            rdy_d = lb_rd_d;
        end
    endtask

    task automatic clear_rdy_log();
        rdy_n = 0;
        rdy_k = -1;
        rdy_d = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        lb_wr     = 1'b0;
        lb_rd     = 1'b0;
        lb_addr   = '0;
        lb_wr_d   = '0;
        ch_rd_d   = '0;
        ch_rd_rdy = '0;
        clear_rdy_log();

        // Table: wr rd addr wd | rdy data err | chk_ch cs_ctrl cs_data ch_wr ch_wr_d
        vecs[0]  = mk(0, 1, 32'h0F0, 32'h0,        1, 32'h53554D50, 16'd0, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h0F4, 32'hA5A55A5A, 0, 32'h0,        16'd0, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 32'h0F4, 32'h0,        1, 32'hA5A55A5A, 16'd0, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[3]  = mk(0, 1, 32'h0F8, 32'h0,        1, 32'h00000004, 16'd0, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[4]  = mk(0, 1, 32'h050, 32'h0,        1, 32'hDEADBEEF, 16'd1, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[5]  = mk(0, 1, 32'h0F8, 32'h0,        1, 32'h00010004, 16'd1, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[6]  = mk(1, 0, 32'h060, 32'h11111111, 0, 32'h0,        16'd2, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[7]  = mk(0, 1, 32'h0FC, 32'h0,        1, 32'hDEADBEEF, 16'd3, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[8]  = mk(1, 0, 32'h0F8, 32'h7FFFFFFF, 0, 32'h0,        16'd3, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[9]  = mk(1, 0, 32'h0F8, 32'h80000000, 0, 32'h0,        16'd0, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[10] = mk(0, 1, 32'h1F0, 32'h0,        1, 32'h53554D50, 16'd0, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[11] = mk(1, 0, 32'h0F0, 32'h00000000, 0, 32'h0,        16'd0, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[12] = mk(0, 1, 32'h0F0, 32'h0,        1, 32'h53554D50, 16'd0, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[13] = mk(1, 0, 32'h014, 32'h00001234, 0, 32'h0,        16'd0, 1, 4'h0, 4'h2, 1, 32'h00001234);
        vecs[14] = mk(1, 0, 32'h038, 32'h0000BEEF, 0, 32'h0,        16'd0, 1, 4'h8, 4'h0, 1, 32'h0000BEEF);
        vecs[15] = mk(0, 1, 32'h040, 32'h0,        1, 32'hDEADBEEF, 16'd1, 0, 4'h0, 4'h0, 0, 32'h0);
        vecs[16] = mk(1, 0, 32'h0F8, 32'h80000000, 0, 32'h0,        16'd0, 0, 4'h0, 4'h0, 0, 32'h0);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk_lb);
        check("rst lb_rd_rdy",  32'(lb_rd_rdy),  32'h0);
        check("rst lb_rd_d",    lb_rd_d,         32'h0);
        check("rst ch_cs_ctrl", 32'(ch_cs_ctrl), 32'h0);
        check("rst ch_cs_data", 32'(ch_cs_data), 32'h0);
        check("rst ch_wr",      32'(ch_wr),      32'h0);
        check("rst ch_rd",      32'(ch_rd),      32'h0);
        check("rst ch_wr_d",    ch_wr_d,         32'h0);
        check("rst err_cnt",    32'(err_cnt),    32'h0);
        reset = 1'b0;

        // ---------------- table-driven single accesses ----------------
        for (int i = 0; i < 17; i++) begin
            bus_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d lb_rd_rdy", i), 32'(lb_rd_rdy), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d lb_rd_d", i),   lb_rd_d,        vecs[i].exp_d);
            check($sformatf("vec%0d err_cnt", i),   32'(err_cnt),   32'(vecs[i].exp_err));
            if (vecs[i].chk_ch) begin
                check($sformatf("vec%0d ch_cs_ctrl", i), 32'(ch_cs_ctrl), 32'(vecs[i].exp_cs_ctrl));
                check($sformatf("vec%0d ch_cs_data", i), 32'(ch_cs_data), 32'(vecs[i].exp_cs_data));
                check($sformatf("vec%0d ch_wr", i),      32'(ch_wr),      32'(vecs[i].exp_ch_wr));
                check($sformatf("vec%0d ch_rd", i),      32'(ch_rd),      32'h0);
                check($sformatf("vec%0d ch_wr_d", i),    ch_wr_d,         vecs[i].exp_ch_wr_d);
            end
        end

        // ---------------- A: channel 2 data read, ready 3 cycles after ch_rd ----
        ch_rd_d[64 +: 32] = 32'h0000CAFE;
        ch_rd_d[32 +: 32] = 32'h0BADF00D;
        clear_rdy_log();
        @(negedge clk_lb);
        lb_rd   = 1'b1;
        lb_addr = 32'h024;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_lb);
            lb_rd = 1'b0;
            note_rdy(k);
            if (k == 1) begin
                check("A ch_rd pulse",   32'(ch_rd),      32'h1);
                check("A ch_cs_data",    32'(ch_cs_data), 32'h4);
                check("A ch_cs_ctrl",    32'(ch_cs_ctrl), 32'h0);
            end
            if (k == 2) check("A ch_rd falls", 32'(ch_rd), 32'h0);
            ch_rd_rdy = (k == 4) ? 4'b0100 : ((k == 2) ? 4'b0010 : 4'b0000);
        end
        check("A rdy count",  32'(rdy_n), 32'h1);
        check("A rdy cycle",  32'(rdy_k), 32'h5);
        check("A rdy data",   rdy_d,      32'h0000CAFE);
        check("A lb_rd_d idle", lb_rd_d,  32'h0);

        // ---------------- B: write+read while busy, both channels ready ------
        ch_rd_d[0  +: 32] = 32'h11112222;
        ch_rd_d[96 +: 32] = 32'h33334444;
        clear_rdy_log();
        @(negedge clk_lb);
        lb_rd   = 1'b1;
        lb_addr = 32'h000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_lb);
            lb_wr = 1'b0;
            lb_rd = 1'b0;
            note_rdy(k);
            ch_rd_rdy = 4'b0000;
            if (k == 1) check("B ch_cs_ctrl", 32'(ch_cs_ctrl), 32'h1);
            if (k == 2) begin
                lb_wr   = 1'b1;
                lb_rd   = 1'b1;
                lb_addr = 32'h034;
                lb_wr_d = 32'h5555AAAA;
            end
            if (k == 3) begin
                check("B busy ch_wr",      32'(ch_wr),      32'h1);
                check("B busy ch_rd",      32'(ch_rd),      32'h0);
                check("B busy ch_cs_data", 32'(ch_cs_data), 32'h8);
                check("B busy ch_wr_d",    ch_wr_d,         32'h5555AAAA);
                check("B busy err_cnt",    32'(err_cnt),    32'h1);
                ch_rd_rdy = 4'b1001;
            end
        end
        check("B rdy count", 32'(rdy_n), 32'h1);
        check("B rdy cycle", 32'(rdy_k), 32'h4);
        check("B rdy data",  rdy_d,      32'h11112222);
        bus_op(1'b1, 1'b0, 32'h0F8, 32'h80000000);
        check("B err clear", 32'(err_cnt), 32'h0);

        // ---------------- C: same-cycle write+read, zero-latency ready -------
        ch_rd_d[0 +: 32] = 32'hA0A0A0A0;
        clear_rdy_log();
        @(negedge clk_lb);
        lb_wr   = 1'b1;
        lb_rd   = 1'b1;
        lb_addr = 32'h004;
        lb_wr_d = 32'hCCCC0000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_lb);
            lb_wr = 1'b0;
            lb_rd = 1'b0;
            note_rdy(k);
            ch_rd_rdy = (k == 1) ? 4'b0001 : 4'b0000;
            if (k == 1) begin
                check("C ch_wr",      32'(ch_wr),      32'h1);
                check("C ch_rd",      32'(ch_rd),      32'h1);
                check("C ch_cs_data", 32'(ch_cs_data), 32'h1);
                check("C ch_wr_d",    ch_wr_d,         32'hCCCC0000);
            end
        end
        check("C rdy count", 32'(rdy_n), 32'h1);
        check("C rdy cycle", 32'(rdy_k), 32'h2);
        check("C rdy data",  rdy_d,      32'hA0A0A0A0);

        // ---------------- F: error counter saturation ------------------------
        // Unmapped write+read every cycle adds two errors per cycle.
        @(negedge clk_lb);
        lb_wr   = 1'b1;
        lb_rd   = 1'b1;
        lb_addr = 32'h050;
        lb_wr_d = 32'h0;
        repeat (32767) @(negedge clk_lb);
        check("F err below sat", 32'(err_cnt), 32'h0000FFFE);
        check("F unmapped data", lb_rd_d,      32'hDEADBEEF);
        @(negedge clk_lb);
        check("F err saturates", 32'(err_cnt), 32'h0000FFFF);
        @(negedge clk_lb);
        check("F err holds",     32'(err_cnt), 32'h0000FFFF);
        lb_wr = 1'b0;
        lb_rd = 1'b0;

        // ---------------- G: clear write + busy-read error in one cycle ------
        ch_rd_d[0 +: 32] = 32'h77778888;
        clear_rdy_log();
        @(negedge clk_lb);
        lb_rd   = 1'b1;
        lb_addr = 32'h000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_lb);
            lb_wr = 1'b0;
            lb_rd = 1'b0;
            note_rdy(k);
            ch_rd_rdy = 4'b0000;
            if (k == 1) check("G err before clear", 32'(err_cnt), 32'h0000FFFF);
            if (k == 2) begin
                lb_wr   = 1'b1;
                lb_rd   = 1'b1;
                lb_addr = 32'h0F8;
                lb_wr_d = 32'h80000000;
            end
            if (k == 3) begin
                check("G clear beats error", 32'(err_cnt), 32'h0);
                ch_rd_rdy = 4'b0001;
            end
        end
        check("G rdy count", 32'(rdy_n), 32'h1);
        check("G rdy cycle", 32'(rdy_k), 32'h4);
        check("G rdy data",  rdy_d,      32'h77778888);

        // ---------------- D: reset while waiting -----------------------------
        clear_rdy_log();
        @(negedge clk_lb);
        lb_rd   = 1'b1;
        lb_addr = 32'h010;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_lb);
            lb_wr = 1'b0;
            lb_rd = 1'b0;
            reset = 1'b0;
            note_rdy(k);
            ch_rd_rdy = (k == 4) ? 4'b0010 : 4'b0000;
            if (k == 2) begin
                // A write presented during reset must be ignored.
                reset   = 1'b1;
                lb_wr   = 1'b1;
                lb_addr = 32'h0F4;
                lb_wr_d = 32'h12345678;
            end
        end
        check("D no rdy after reset", 32'(rdy_n),      32'h0);
        check("D cs_ctrl cleared",    32'(ch_cs_ctrl), 32'h0);
        check("D ch_wr_d cleared",    ch_wr_d,         32'h0);
        bus_op(1'b0, 1'b1, 32'h0F4, 32'h0);
        check("D scratch rdy",   32'(lb_rd_rdy), 32'h1);
        check("D scratch zero",  lb_rd_d,        32'h0);
        bus_op(1'b0, 1'b1, 32'h0F0, 32'h0);
        check("D id rdy",        32'(lb_rd_rdy), 32'h1);
        check("D id data",       lb_rd_d,        32'h53554D50);
        check("D err after",     32'(err_cnt),   32'h0);

        // ---------------- E: no-ready read, with second read while busy ------
        clear_rdy_log();
        ch_rd_d[0 +: 32] = 32'h0F0F0F0F;
        @(negedge clk_lb);
        lb_rd   = 1'b1;
        lb_addr = 32'h000;
`ifdef CORE_LB_TIMEOUT_EN
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_lb);
            lb_rd = 1'b0;
            note_rdy(k);
            if (k == 3) begin
                lb_rd   = 1'b1;
                lb_addr = 32'h0F0;
            end
            if (k == 4) check("E busy read err", 32'(err_cnt), 32'h1);
        end
        check("E timeout rdy count", 32'(rdy_n),    32'h1);
        check("E timeout rdy cycle", 32'(rdy_k),    32'h9);
        check("E timeout data",      rdy_d,         32'hDEADBEEF);
        check("E timeout err_cnt",   32'(err_cnt),  32'h2);
`else
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_lb);
            lb_rd = 1'b0;
            note_rdy(k);
            ch_rd_rdy = (k == 25) ? 4'b0001 : 4'b0000;
            if (k == 3) begin
                lb_rd   = 1'b1;
                lb_addr = 32'h0F0;
            end
            if (k == 4)  check("E busy read err", 32'(err_cnt), 32'h1);
            if (k == 24) check("E still waiting", 32'(rdy_n),   32'h0);
        end
        check("E late rdy count", 32'(rdy_n),   32'h1);
        check("E late rdy cycle", 32'(rdy_k),   32'd26);
        check("E late data",      rdy_d,        32'h0F0F0F0F);
        check("E err_cnt",        32'(err_cnt), 32'h1);
`endif
        bus_op(1'b1, 1'b0, 32'h0F8, 32'h80000000);
        check("E err clear", 32'(err_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_lb_hub.md
CORE_LB_HUB -- requirements
Module: core_lb_hub

Interface
REQ-001 Parameter NUM_CH, default 4, legal 1..8: number of capture-channel slaves (sump2 instances) behind the hub.
REQ-002 Parameter TIMEOUT_CYC, default 255, legal 2..65535: cycles a channel read may wait for ready.
REQ-003 Parameter HUB_ID, default 32'h53554D50: constant returned by the ID register.
REQ-004 Clock and reset: one clock clk_lb; reset is synchronous and active-high.
REQ-005 Port list, one per line: name, direction, width, meaning.
- clk_lb  in  1  local-bus clock, all logic rising-edge
- reset  in  1  synchronous active-high reset
- lb_wr  in  1  single-cycle write strobe
- lb_rd  in  1  single-cycle read strobe
- lb_addr  in  32  byte address
- lb_wr_d  in  32  write data
- lb_rd_d  out  32  read data, valid while lb_rd_rdy=1, else 0
- lb_rd_rdy  out  1  single-cycle read-complete pulse
- ch_cs_ctrl  out  NUM_CH  per-channel control-register select
- ch_cs_data  out  NUM_CH  per-channel data-register select
- ch_wr  out  1  forwarded write strobe
- ch_rd  out  1  forwarded read strobe
- ch_wr_d  out  32  forwarded write data
- ch_rd_d  in  NUM_CH*32  channel read data, channel k at [32k+31:32k]
- ch_rd_rdy  in  NUM_CH  channel read-ready pulses
- err_cnt  out  16  saturating bus-error count

Function
REQ-006 Decode: lb_addr[7:4]=k with k<NUM_CH selects channel k; lb_addr[2]=0 selects ctrl, 1 selects data; lb_addr[7:4]=4'hF selects hub registers; all other values are unmapped; lb_addr[31:8] ignored.
REQ-007 Channel access is registered: ch_cs_*, ch_wr, ch_rd, ch_wr_d update the cycle after the lb strobe; ch_wr/ch_rd are one-cycle pulses; ch_cs_* hold until the next accepted access.
REQ-008 Hub registers: 0xF0 ID (read-only, HUB_ID); 0xF4 scratch (read/write, 32 bits); 0xF8 status = {err_cnt[15:0], 12'd0, NUM_CH[3:0]}; writing 0xF8 with bit31=1 clears err_cnt.
REQ-009 Hub-register and unmapped reads: lb_rd_rdy pulses exactly 1 cycle after lb_rd; unmapped read returns 32'hDEADBEEF and increments err_cnt; unmapped writes are dropped and increment err_cnt.
REQ-010 Read FSM states IDLE, WAIT, DONE; IDLE->WAIT when a channel read is forwarded; WAIT->DONE when ch_rd_rdy of the selected channel is 1, capturing that channel's ch_rd_d; DONE drives lb_rd_rdy=1 for one cycle, then ->IDLE.
REQ-011 Channel read latency: lb_rd_rdy = slave ready latency + 2 cycles after lb_rd; ch_rd_rdy of non-selected channels is ignored in every state.
REQ-012 lb_rd received while not IDLE is not forwarded, gets no lb_rd_rdy, increments err_cnt; lb_wr while not IDLE is forwarded normally.
REQ-013 lb_wr and lb_rd in the same cycle: write performed and read processed to the same address; ch_wr and ch_rd both pulse.
REQ-014 err_cnt saturates at 16'hFFFF; clear-write and an error in the same cycle leave err_cnt=0.

Reset
REQ-015 Reset forces FSM to IDLE, abandons any pending read without lb_rd_rdy, and zeroes lb_rd_d, lb_rd_rdy, ch_cs_*, ch_wr, ch_rd, ch_wr_d, scratch, err_cnt, timeout counter.
REQ-016 Strobes in a cycle where reset=1 are ignored.

Configuration
REQ-017 Macro CORE_LB_TIMEOUT_EN defined: in WAIT a counter runs from 0; at TIMEOUT_CYC cycles without ready, FSM ->DONE returning 32'hDEADBEEF and err_cnt increments; ready in the same cycle as timeout wins.
REQ-018 Macro CORE_LB_TIMEOUT_EN undefined: no counter logic; WAIT holds until selected ready or reset.

Verification
REQ-019 Read 0xF0 after reset -> lb_rd_rdy 1 cycle later, lb_rd_d=32'h53554D50.
REQ-020 Write 0xF4=32'hA5A55A5A, read 0xF4 -> 32'hA5A55A5A; read 0xF8 with NUM_CH=4 -> 32'h00000004.
REQ-021 Read 0x24, channel 2 asserts ready 3 cycles after ch_rd with 32'h0000CAFE -> ch_cs_data=4'b0100, lb_rd_rdy 5 cycles after lb_rd, data 32'h0000CAFE; ready on channel 1 during WAIT ignored.
REQ-022 Read 0x50 with NUM_CH=4 -> 32'hDEADBEEF after 1 cycle, err_cnt=1; write 0xF8=32'h80000000 -> err_cnt=0.
REQ-023 With CORE_LB_TIMEOUT_EN, TIMEOUT_CYC=8, read 0x00 and no ready -> 32'hDEADBEEF, err_cnt=1; second lb_rd during WAIT -> no response, err_cnt=2.
REQ-024 Reset asserted in WAIT -> no lb_rd_rdy, FSM IDLE, subsequent read 0xF0 completes normally.
